// File: rtl/fifoarb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding and counter sizing.
package fifoarb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int                     COUNT_WIDTH = 16;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = '1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from last+1, with wrap.
module rr_pick
    import fifoarb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PTRW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] last,
    output logic [NREQ-1:0] winner,
    output logic [PTRW-1:0] winner_idx,
    output logic            valid
);

    int idx;

    // NOTE: every output gets a default before the search loop so no path leaves one unassigned (no latch).
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        idx        = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last) + off) % NREQ;
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = PTRW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters, with optional packet lock.
// Define FIFOARB_STATS_EN to build the per-requester saturating accept counters.
module fifo_write_arbiter
    import fifoarb_pkg::*;
#(
    parameter int ELEMENTWIDTH = 8,
    parameter int NREQ         = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              Req,
    input  logic [NREQ-1:0]              ReqLock,
    input  logic [NREQ*ELEMENTWIDTH-1:0] ReqData,
    output logic [NREQ-1:0]              Grant,
    input  logic                         FifoFull,
    output logic                         FifoWriteEnable,
    output logic [ELEMENTWIDTH-1:0]      FifoDataWrite,
    output logic                         Locked,
    output logic [NREQ*COUNT_WIDTH-1:0]  AcceptCount
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_next;
    logic [PTRW-1:0] last, last_next;
    logic [PTRW-1:0] owner, owner_next;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] pick_onehot;
    logic [PTRW-1:0] pick_idx;
    logic            pick_valid;

    // While locked only the owner's request is visible; a full FIFO hides everyone.
    always_comb begin
        mask = '0;
        if (!FifoFull) begin
            if (state == LOCKED) mask[owner] = Req[owner];
            else                 mask        = Req;
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick (
        .req        (mask),
        .last       (last),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        if (pick_valid) last_next = pick_idx;
        case (state)
            IDLE: begin
                if (pick_valid && ReqLock[pick_idx]) begin
                    state_next = LOCKED;
                    owner_next = pick_idx;
                end
            end
            LOCKED: begin
                // Leave after the final word, or when the owner walks away without a request.
                if (!ReqLock[owner] && (pick_valid || !Req[owner])) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            last            <= PTRW'(NREQ - 1);
            owner           <= '0;
            Grant           <= '0;
            FifoWriteEnable <= 1'b0;
            FifoDataWrite   <= '0;
        end else begin
            state           <= state_next;
            last            <= last_next;
            owner           <= owner_next;
            Grant           <= pick_onehot;
            FifoWriteEnable <= pick_valid;
            if (pick_valid) FifoDataWrite <= ReqData[int'(pick_idx)*ELEMENTWIDTH +: ELEMENTWIDTH];
        end
    end

    assign Locked = (state == LOCKED);

`ifdef FIFOARB_STATS_EN
    logic [COUNT_WIDTH-1:0] count [NREQ];

    // NOTE: the counter array is reset element by element; it is a small register file, not a RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) count[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (pick_onehot[i] && count[i] != COUNT_MAX) count[i] <= count[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_count
        assign AcceptCount[g*COUNT_WIDTH +: COUNT_WIDTH] = count[g];
    end
`else
    assign AcceptCount = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: stimulus queues expected writes, a monitor checks them.
module tb_fifo_write_arbiter;

    localparam int W = 8;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   Req;
    logic [N-1:0]   ReqLock;
    logic [N*W-1:0] ReqData;
    logic [N-1:0]   Grant;
    logic           FifoFull;
    logic           FifoWriteEnable;
    logic [W-1:0]   FifoDataWrite;
    logic           Locked;
    logic [N*16-1:0] AcceptCount;

    typedef struct packed {
        logic [N-1:0] g;
        logic [W-1:0] d;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt [N];

    fifo_write_arbiter #(.ELEMENTWIDTH(W), .NREQ(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .Req             (Req),
        .ReqLock         (ReqLock),
        .ReqData         (ReqData),
        .Grant           (Grant),
        .FifoFull        (FifoFull),
        .FifoWriteEnable (FifoWriteEnable),
        .FifoDataWrite   (FifoDataWrite),
        .Locked          (Locked),
        .AcceptCount     (AcceptCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] r, input logic [1:0] l,
                        input logic [7:0] d0, input logic [7:0] d1, input logic f);
        @(negedge clk);
        Req      = r;
        ReqLock  = l;
        ReqData  = {d1, d0};
        FifoFull = f;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_w(input logic [1:0] g, input logic [7:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        q.push_back(e);
        for (int i = 0; i < N; i++)
            if (g[i] && exp_cnt[i] < 65535) exp_cnt[i]++;
    endtask

    task automatic check_counts(input string name);
        logic [31:0] exp_acc;
`ifdef FIFOARB_STATS_EN
        exp_acc = {exp_cnt[1][15:0], exp_cnt[0][15:0]};
`else
        exp_acc = 32'h0;
`endif
        check(name, AcceptCount, exp_acc);
    endtask

    // Monitor: pops one expected write per observed FifoWriteEnable.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (FifoWriteEnable) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: got grant %b data %h, expected no write", Grant, FifoDataWrite);
                    end else begin
                        e = q.pop_front();
                        check("grant", Grant, e.g);
                        check("data", FifoDataWrite, e.d);
                    end
                end else begin
                    check("idle_grant", Grant, '0);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        Req      = '0;
        ReqLock  = '0;
        ReqData  = '0;
        FifoFull = 1'b0;
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        #1;
        check("rst_grant", Grant, '0);
        check("rst_we", FifoWriteEnable, 0);
        check("rst_data", FifoDataWrite, 0);
        check("rst_locked", Locked, 0);
        check("rst_count", AcceptCount, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single uncontended write from requester 0.
        expect_w(2'b01, 8'hA5);
        step(2'b01, 2'b00, 8'hA5, 8'h00, 1'b0);
        check_counts("count_first");
        step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);

        // Requester 1 once, so the pointer sits on 1 before the contention run.
        expect_w(2'b10, 8'h5A);
        step(2'b10, 2'b00, 8'h00, 8'h5A, 1'b0);

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) expect_w(2'b01, 8'h10);
            else            expect_w(2'b10, 8'h20);
            step(2'b11, 2'b00, 8'h10, 8'h20, 1'b0);
        end

        // Full FIFO blocks everything; on release requester 0 follows Last=1.
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 2'b00, 8'h40, 8'h50, 1'b1);
            check("full_we", FifoWriteEnable, 0);
        end
        expect_w(2'b01, 8'h40);
        step(2'b11, 2'b00, 8'h40, 8'h50, 1'b0);
        step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);

        // Locked 3-word packet from requester 1 while requester 0 waits.
        expect_w(2'b10, 8'h31);
        step(2'b11, 2'b10, 8'h77, 8'h31, 1'b0);
        check("lock_w1", Locked, 1);
        expect_w(2'b10, 8'h32);
        step(2'b11, 2'b10, 8'h77, 8'h32, 1'b0);
        check("lock_w2", Locked, 1);
        expect_w(2'b10, 8'h33);
        step(2'b11, 2'b00, 8'h77, 8'h33, 1'b0);
        check("lock_w3", Locked, 0);
        expect_w(2'b01, 8'h77);
        step(2'b01, 2'b00, 8'h77, 8'h00, 1'b0);
        step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);

        // Abandoned lock: owner holds lock without data, then drops both.
        expect_w(2'b10, 8'h41);
        step(2'b10, 2'b10, 8'h00, 8'h41, 1'b0);
        check("abandon_lock", Locked, 1);
        step(2'b01, 2'b10, 8'h55, 8'h00, 1'b0);
        check("abandon_hold", Locked, 1);
        step(2'b01, 2'b00, 8'h55, 8'h00, 1'b0);
        check("abandon_drop", Locked, 0);
        expect_w(2'b01, 8'h55);
        step(2'b01, 2'b00, 8'h55, 8'h00, 1'b0);
        step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a locked packet.
        expect_w(2'b10, 8'h61);
        step(2'b10, 2'b10, 8'h00, 8'h61, 1'b0);
        check("pre_rst_locked", Locked, 1);
        #2;
        reset = 1'b1;
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        #1;
        check("async_grant", Grant, '0);
        check("async_we", FifoWriteEnable, 0);
        check("async_locked", Locked, 0);
        check("async_data", FifoDataWrite, 0);
        check_counts("async_count");
        @(negedge clk);
        Req     = '0;
        ReqLock = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_w(2'b01, 8'h81);
        step(2'b11, 2'b00, 8'h81, 8'h82, 1'b0);
        check_counts("count_after_rst");
        step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);

`ifdef FIFOARB_STATS_EN
        for (int i = 0; i < 65537; i++) begin
            expect_w(2'b01, 8'h99);
            step(2'b01, 2'b00, 8'h99, 8'h00, 1'b0);
        end
        step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
        check("count_saturate", AcceptCount[15:0], 16'hFFFF);
`endif

        step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
        check_counts("count_final");
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
